// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the NMI arbiter.
// Pure definitions; no timing or flow-control behaviour of its own.
package nmi_arb_pkg;

  localparam int NUM_MSTR_DEF    = 2;
  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int IDX_W           = 2;
  localparam int CNT_W           = 16;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
    if (idx == IDX_W'(n - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/nmi_if.sv
// Single downstream NMI port: valid/addr/wdata/wstrb towards the slave, rdata/ready back.
// The slave completes a beat by raising ready while valid is high.
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/nmi_rr_pick.sv
// Round-robin pick: first set request at or above ptr_i, wrapping at N.
// Purely combinational; no backpressure.
module nmi_rr_pick
  import nmi_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any_o && (j == ((int'(ptr_i) + i) % N)) && req_i[j]) begin
          any_o = 1'b1;
          idx_o = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter of NUM_MSTR masters onto one NMI port; grant one cycle after request,
// completion passes through combinationally, stalled slaves are cut off after TIMEOUT_CYC cycles.
module nmi_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int NUM_MSTR    = NUM_MSTR_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_MSTR-1:0]    mstr_valid_i,
  input  logic [NUM_MSTR*32-1:0] mstr_addr_i,
  input  logic [NUM_MSTR*32-1:0] mstr_wdata_i,
  input  logic [NUM_MSTR*4-1:0]  mstr_wstrb_i,
  output logic [NUM_MSTR-1:0]    mstr_ready_o,
  output logic [31:0]           mstr_rdata_o,
  nmi_if.master                 nmi,
  input  logic                  err_clr_i,
  output logic                  err_o,
  output logic [31:0]           err_addr_o,
  output logic [1:0]            err_mstr_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [1:0]         err_mstr_q, err_mstr_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               sel_vld;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_wstrb;
  logic [NUM_MSTR-1:0] gnt_oh;
  logic               timeout;
  logic               nmi_vld;

  nmi_rr_pick #(.N(NUM_MSTR)) u_pick (
    .req_i (mstr_valid_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_vld   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    gnt_oh    = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        sel_vld   = mstr_valid_i[i];
        sel_addr  = mstr_addr_i[i*32 +: 32];
        sel_wdata = mstr_wdata_i[i*32 +: 32];
        sel_wstrb = mstr_wstrb_i[i*4 +: 4];
        gnt_oh[i] = 1'b1;
      end
    end
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    cnt_d        = '0;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    err_mstr_d   = err_mstr_q;
    nmi_vld      = 1'b0;
    mstr_ready_o = '0;
    mstr_rdata_o = '0;

    // A timeout in the same cycle overrides the clear below.
    if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
      err_mstr_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!sel_vld) begin
          state_d = ST_IDLE;
        end else if (nmi.ready) begin
          nmi_vld      = 1'b1;
          mstr_ready_o = gnt_oh;
          mstr_rdata_o = nmi.rdata;
          ptr_d        = next_idx(gnt_q, NUM_MSTR);
          state_d      = ST_IDLE;
        end else if (timeout) begin
          mstr_ready_o = gnt_oh;
          mstr_rdata_o = ERR_RDATA;
          err_d        = 1'b1;
          err_addr_d   = sel_addr;
          err_mstr_d   = 2'(gnt_q);
          ptr_d        = next_idx(gnt_q, NUM_MSTR);
          state_d      = ST_IDLE;
        end else begin
          nmi_vld = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst_n_i) begin
      nmi_vld      = 1'b0;
      mstr_ready_o = '0;
    end
  end

  assign nmi.valid = nmi_vld;
  assign nmi.addr  = sel_addr;
  assign nmi.wdata = sel_wdata;
  assign nmi.wstrb = sel_wstrb;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_mstr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_mstr_q <= err_mstr_d;
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign err_mstr_o = err_mstr_q;

endmodule

// File: tb/tb_nmi_arbiter.sv
// Directed bench for nmi_arbiter: two masters, TIMEOUT_CYC = 8, slave behaviour selectable per phase.
module tb_nmi_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mvld;
  logic [63:0] maddr;
  logic [63:0] mwdata;
  logic [7:0]  mwstrb;
  logic [1:0]  mrdy;
  logic [31:0] mrdata;
  logic        err_clr;
  logic        err;
  logic [31:0] err_addr;
  logic [1:0]  err_mstr;

  // Slave model: 0 = manual ready, 1 = zero-wait, 2 = ready one cycle after valid.
  int          slv_mode;
  logic        slv_rdy;
  logic [31:0] slv_rdata;
  logic        slv_d1;

  int n_tests;
  int n_fail;

  nmi_if u_nmi ();

  assign u_nmi.rdata = slv_rdata;
  assign u_nmi.ready = (slv_mode == 1) ? u_nmi.valid :
                       (slv_mode == 2) ? (u_nmi.valid & slv_d1) : slv_rdy;

  always @(posedge clk) slv_d1 <= u_nmi.valid & ~u_nmi.ready;

  nmi_arbiter #(.NUM_MSTR(2), .TIMEOUT_CYC(8)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .mstr_valid_i (mvld),
    .mstr_addr_i  (maddr),
    .mstr_wdata_i (mwdata),
    .mstr_wstrb_i (mwstrb),
    .mstr_ready_o (mrdy),
    .mstr_rdata_o (mrdata),
    .nmi          (u_nmi),
    .err_clr_i    (err_clr),
    .err_o        (err),
    .err_addr_o   (err_addr),
    .err_mstr_o   (err_mstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mvld      = '0;
    maddr     = {32'h1000_1000, 32'h3000_0000};
    mwdata    = '0;
    mwstrb    = '0;
    err_clr   = 1'b0;
    slv_mode  = 0;
    slv_rdy   = 1'b0;
    slv_rdata = '0;

    // Reset state
    cyc(); cyc(); mid();
    check("rst_nmi_valid", 32'(u_nmi.valid), 0);
    check("rst_ready", 32'(mrdy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_mstr", 32'(err_mstr), 0);
    cyc(); rst_n = 1'b1;

    // Master 1 only, zero-wait read
    cyc(); mvld = 2'b10; slv_mode = 1; slv_rdata = 32'h0000_00A5; mid();
    check("A_c0_valid", 32'(u_nmi.valid), 0);
    check("A_c0_ready", 32'(mrdy), 0);
    cyc(); mid();
    check("A_c1_valid", 32'(u_nmi.valid), 1);
    check("A_c1_addr", u_nmi.addr, 32'h1000_1000);
    check("A_c1_ready", 32'(mrdy), 32'h2);
    check("A_c1_rdata", mrdata, 32'h0000_00A5);
    cyc(); mvld = 2'b00; mid();
    check("A_c2_valid", 32'(u_nmi.valid), 0);
    check("A_c2_ready", 32'(mrdy), 0);

    // Both masters, slave one cycle late: grants 0,1,0,1
    cyc(); mvld = 2'b11; slv_mode = 2;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      mid();
      check($sformatf("B_rr_k%0d", k), 32'(mrdy),
            (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
    end
    cyc(); mvld = 2'b00; slv_mode = 0; slv_rdy = 1'b0;

    // Timeout on master 0 at 0x3000_0000
    cyc(); mvld = 2'b01;
    for (int b = 1; b <= 8; b++) begin
      cyc(); mid();
      if (b < 8) begin
        check($sformatf("C_b%0d_ready", b), 32'(mrdy), 0);
        if (b == 7) check("C_b7_valid", 32'(u_nmi.valid), 1);
      end else begin
        check("C_b8_valid", 32'(u_nmi.valid), 0);
        check("C_b8_ready", 32'(mrdy), 32'h1);
        check("C_b8_rdata", mrdata, 32'hDEAD_BEEF);
        check("C_b8_err_pre", 32'(err), 0);
      end
    end
    cyc(); mvld = 2'b00; mid();
    check("C_err", 32'(err), 1);
    check("C_err_addr", err_addr, 32'h3000_0000);
    check("C_err_mstr", 32'(err_mstr), 0);

    // Clear, then clear coinciding with a second timeout
    cyc(); err_clr = 1'b1;
    cyc(); err_clr = 1'b0; mvld = 2'b01; maddr[31:0] = 32'h3000_0004; mid();
    check("D_err_cleared", 32'(err), 0);
    for (int b = 1; b <= 8; b++) begin
      cyc();
      if (b == 8) err_clr = 1'b1;
      mid();
      if (b == 8) check("D_b8_ready", 32'(mrdy), 32'h1);
    end
    cyc(); err_clr = 1'b0; mvld = 2'b00; mid();
    check("D_err_kept", 32'(err), 1);
    check("D_err_addr", err_addr, 32'h3000_0004);

    // Reset in BUSY cycle 3 of a master-1 write
    cyc(); mvld = 2'b10; mwstrb = 8'hF0; mwdata = {32'h1234_5678, 32'h0};
    cyc(); mid();
    check("E_wstrb", 32'(u_nmi.wstrb), 32'hF);
    check("E_wdata", u_nmi.wdata, 32'h1234_5678);
    cyc();
    cyc(); rst_n = 1'b0; slv_rdy = 1'b1; mid();
    check("E_rst_valid", 32'(u_nmi.valid), 0);
    check("E_rst_ready", 32'(mrdy), 0);
    cyc(); rst_n = 1'b1; slv_rdy = 1'b0; mvld = 2'b11; mid();
    check("E_post_valid", 32'(u_nmi.valid), 0);
    check("E_post_err", 32'(err), 0);
    cyc(); slv_rdy = 1'b1; mid();
    check("E_ptr0_addr", u_nmi.addr, 32'h3000_0004);
    check("E_ptr0_ready", 32'(mrdy), 32'h1);
    cyc(); mvld = 2'b10; mid();
    check("E_idle_ready_ignored", 32'(mrdy), 0);
    cyc(); mid();
    check("E_m1_ready", 32'(mrdy), 32'h2);
    cyc(); mvld = 2'b00; slv_rdy = 1'b0; mwstrb = '0;

    // Master 0 drops valid in BUSY cycle 2
    cyc(); mvld = 2'b01;
    cyc(); mid();
    check("F_b1_valid", 32'(u_nmi.valid), 1);
    cyc(); mvld = 2'b00; slv_rdy = 1'b1; mid();
    check("F_drop_ready", 32'(mrdy), 0);
    check("F_drop_valid", 32'(u_nmi.valid), 0);
    cyc(); mvld = 2'b11; slv_rdy = 1'b0;
    cyc(); slv_rdy = 1'b1; mid();
    check("F_regrant_addr", u_nmi.addr, 32'h3000_0004);
    check("F_regrant_ready", 32'(mrdy), 32'h1);
    cyc(); mvld = 2'b00; slv_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nmi_arbiter.md
NMI_ARBITER -- requirements
Module: nmi_arbiter

Interface
REQ-001 SHALL have parameter NUM_MSTR, default 2: number of upstream NMI masters (range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum BUSY cycles before a transaction is force-terminated (range 1..65535).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  clock; rst_n_i  input  1  reset.
REQ-004 SHALL have mstr_valid_i  input  NUM_MSTR  per-master request.
REQ-005 SHALL have mstr_addr_i  input  NUM_MSTR x 32  per-master address.
REQ-006 SHALL have mstr_wdata_i  input  NUM_MSTR x 32  per-master write data.
REQ-007 SHALL have mstr_wstrb_i  input  NUM_MSTR x 4  per-master byte strobes; 0 means read.
REQ-008 SHALL have mstr_ready_o  output  NUM_MSTR  per-master completion, one-hot or zero.
REQ-009 SHALL have mstr_rdata_o  output  32  read data, shared by all masters, valid only with a mstr_ready_o bit.
REQ-010 SHALL have nmi  nmi_if.master  -  single downstream port (valid/addr/wdata/wstrb out, rdata/ready in).
REQ-011 SHALL have err_clr_i  input  1  one-cycle pulse that clears the error record.
REQ-012 SHALL have err_o  output  1  sticky timeout flag.
REQ-013 SHALL have err_addr_o  output  32  address of the most recent timed-out transaction.
REQ-014 SHALL have err_mstr_o  output  2  index of the master that owned the timed-out transaction.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY, plus a grant index gnt and a round-robin pointer ptr.
REQ-016 IDLE: if any mstr_valid_i is set, SHALL latch gnt = first valid index searching from ptr upward with wrap, and move to BUSY on the next edge.
REQ-017 IDLE: SHALL hold nmi.valid = 0 and mstr_ready_o = 0.
REQ-018 BUSY: SHALL drive nmi.valid = mstr_valid_i[gnt] and nmi addr/wdata/wstrb from master gnt, combinationally.
REQ-019 BUSY: when nmi.ready = 1, SHALL in the same cycle assert mstr_ready_o[gnt] = 1 and mstr_rdata_o = nmi.rdata, then set ptr = (gnt+1) mod NUM_MSTR and return to IDLE.
REQ-020 Min latency: request at cycle 0 gives nmi.valid at cycle 1; a zero-wait slave completes at cycle 1; the next grant goes out at cycle 2.
REQ-021 BUSY: a 16-bit counter SHALL clear on entry and increment each cycle without nmi.ready.
REQ-022 Timeout: when the counter reaches TIMEOUT_CYC-1 without nmi.ready, SHALL in that cycle force nmi.valid = 0, mstr_ready_o[gnt] = 1 and mstr_rdata_o = ERR_RDATA (32'hDEAD_BEEF).
REQ-023 Timeout: SHALL set err_o = 1, capture err_addr_o and err_mstr_o, advance ptr and return to IDLE.
REQ-024 nmi.ready in the timeout cycle SHALL win: this is a normal completion with no error.
REQ-025 BUSY: if mstr_valid_i[gnt] drops before ready (protocol violation), SHALL return to IDLE with no ready and ptr unchanged.
REQ-026 Simultaneous err_clr_i and timeout: the new error SHALL win (err_o stays 1, new address captured).
REQ-027 nmi.ready while IDLE SHALL be ignored.
REQ-028 A master with no request SHALL never receive ready.
REQ-029 Masters not granted SHALL see mstr_ready_o = 0 regardless of nmi.ready.

Reset
REQ-030 On rst_n_i low, SHALL set state = IDLE, gnt = 0, ptr = 0, counter = 0, err_o = 0, err_addr_o = 0, err_mstr_o = 0.
REQ-031 During reset, SHALL hold nmi.valid = 0 and mstr_ready_o = 0 combinationally.
REQ-032 Reset mid-BUSY SHALL abandon the transaction with no ready issued.

Structure
REQ-033 Package nmi_arb_pkg SHALL hold the state enum, ERR_RDATA, and the NUM_MSTR and TIMEOUT_CYC defaults.
REQ-034 The round-robin search SHALL be one combinational sub-module, nmi_rr_pick (req vector, ptr in; index and any-valid out).

Verification
REQ-035 Masters 0 and 1 both requesting, slave ready 1 cycle after valid: grants SHALL go 0,1,0,1; ready never on both masters in one cycle.
REQ-036 Master 1 only, reads 0x1000_1000, slave returns 0x0000_00A5 with zero wait: mstr_ready_o = 2'b10 with rdata 0xA5 at cycle 1; nmi.valid low at cycle 2.
REQ-037 TIMEOUT_CYC = 8, master 0 reads 0x3000_0000, slave never ready: at BUSY cycle 8, ready[0] = 1 with rdata 0xDEADBEEF; err_o = 1, err_addr_o = 0x3000_0000, err_mstr_o = 0.
REQ-038 err_clr_i pulse after REQ-037: err_o = 0 next cycle; a pulse coinciding with a second timeout at 0x3000_0004 leaves err_o = 1 and err_addr_o = 0x3000_0004.
REQ-039 rst_n_i low for 1 cycle at BUSY cycle 3 of a write: no ready issued; nmi.valid = 0 during reset; state IDLE and ptr = 0 afterward.
REQ-040 Master 0 drops valid in BUSY cycle 2: no ready; ptr unchanged; the next grant goes to master 0 again if it re-requests with master 1 also requesting.
